// File: rtl/serial_adder_if.sv
// -----------------------------------------------------------------------------
// serial_adder_if
// Operand/result handshake bundle for serial_adder.
//
// Parameters
//    WIDTH      operand/result width in bits (2..32)
//
// Signals
//    in_valid   operands a, b, cin valid              (master -> slave)
//    in_ready   adder can accept operands             (slave  -> master)
//    a, b       addends, unsigned or two's complement (master -> slave)
//    cin        carry into bit 0                      (master -> slave)
//    out_valid  sum/cout valid                        (slave  -> master)
//    out_ready  downstream accepts the result         (master -> slave)
//    sum        result bits                           (slave  -> master)
//    cout       carry out of bit WIDTH-1              (slave  -> master)
//    busy       addition in progress                  (slave  -> master)
//    ovf        signed overflow, only when SERIAL_ADDER_OVF_EN is defined
//
// Modports
//    slave      the adder side
//    master     the side that supplies operands and consumes results
// -----------------------------------------------------------------------------
interface serial_adder_if #(
   parameter int unsigned WIDTH = 8
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf;
`endif

`ifdef SERIAL_ADDER_OVF_EN
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy, ovf
   );

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy, ovf
   );
`else
   modport slave (
      input  in_valid, a, b, cin, out_ready,
      output in_ready, out_valid, sum, cout, busy
   );

   modport master (
      output in_valid, a, b, cin, out_ready,
      input  in_ready, out_valid, sum, cout, busy
   );
`endif

endinterface

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder. One WIDTH-bit addition a + b + cin is computed LSB-first,
// one bit per clock, using a single full adder. Operands are taken through a
// valid/ready handshake in IDLE, the ADD state lasts exactly WIDTH cycles, and
// the result is presented in DONE until the consumer accepts it.
//
// Parameters
//    WIDTH   operand/result width in bits (legal range 2..32)
//
// Ports
//    clk     single clock, all state on the rising edge
//    rst_n   asynchronous active-low reset
//    bus     serial_adder_if.slave:
//               in_valid/in_ready/a/b/cin   operand handshake
//               out_valid/out_ready/sum/cout result handshake
//               busy                        high while in ADD
//               ovf                         signed overflow (optional)
//
// Build options
//    SERIAL_ADDER_OVF_EN  when defined, adds the ovf output: in DONE it holds
//                         (carry into MSB) ^ (carry out of MSB); it is 0 after
//                         reset and cleared when new operands are accepted.
//
// Timing
//    Accept at edge T, bits computed on edges T+1..T+WIDTH, out_valid high
//    from the cycle after T+WIDTH. With out_ready held high one addition
//    completes every WIDTH+2 cycles.
// -----------------------------------------------------------------------------
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   serial_adder_if.slave  bus
);

   // Counter only needs to reach WIDTH-1; WIDTH >= 2 keeps this at least 1.
   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      StIdle,
      StAdd,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  sum_q, sum_d;
   logic              carry_q, carry_d;
   logic              cout_q, cout_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

`ifdef SERIAL_ADDER_OVF_EN
   logic              ovf_q, ovf_d;
`endif

   // Full adder on the current LSBs of the operand shift registers.
   logic bit_s;
   logic carry_next;
   logic last_bit;

   always_comb begin
      bit_s      = a_q[0] ^ b_q[0] ^ carry_q;
      carry_next = (a_q[0] & b_q[0]) | ((a_q[0] | b_q[0]) & carry_q);
      last_bit   = (cnt_q == CntW'(WIDTH - 1));
   end

   // ---------------------------------------------------------------------------
   // Next-state and datapath
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif

      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               state_d = StAdd;
               a_d     = bus.a;
               b_d     = bus.b;
               carry_d = bus.cin;
               cnt_d   = '0;
               sum_d   = '0;
               cout_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
               ovf_d   = 1'b0;
`endif
            end
         end

         StAdd: begin
            // New bit enters at the MSB side; after WIDTH shifts bit i sits at i.
            sum_d   = {bit_s, sum_q[WIDTH-1:1]};
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            carry_d = carry_next;
            cnt_d   = cnt_q + CntW'(1);
            if (last_bit) begin
               state_d = StDone;
               cnt_d   = '0;
               cout_d  = carry_next;
`ifdef SERIAL_ADDER_OVF_EN
               // carry_q is the carry into the MSB while the MSB is being added.
               ovf_d   = carry_q ^ carry_next;
`endif
            end
         end

         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end
`endif

   // ---------------------------------------------------------------------------
   // Outputs: handshake flags decode the state only
   // ---------------------------------------------------------------------------
   assign bus.in_ready  = (state_q == StIdle);
   assign bus.busy      = (state_q == StAdd);
   assign bus.out_valid = (state_q == StDone);
   assign bus.sum       = sum_q;
   assign bus.cout      = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign bus.ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH = 8). A cycle-level reference
// model (plain integer arithmetic plus a latency count) is compared with the
// DUT every falling edge; directed vectors carry hand-computed results.
// Define SERIAL_ADDER_OVF_EN for both RTL and bench to exercise ovf.
// -----------------------------------------------------------------------------
module tb_serial_adder;

   localparam int unsigned WIDTH    = 8;
   localparam int          MAX_WAIT = 2 * WIDTH + 10;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   serial_adder_if #(.WIDTH(WIDTH)) bus ();

   serial_adder #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                              input logic c);
      return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
   endfunction

   // Signed overflow: like-signed operands giving a result of the other sign.
   function automatic logic ref_ovf(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic c);
      logic [WIDTH:0] r;
      r = ref_add(x, y, c);
      return (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
   endfunction

   // ---------------------------------------------------------------------------
   // Reference model: phase 0 idle, 1 adding (m_left cycles to go), 2 done
   // ---------------------------------------------------------------------------
   int               m_phase;
   int               m_left;
   logic [WIDTH:0]   m_res;
   logic             m_ovf_pend;
   logic [WIDTH-1:0] m_sum;
   logic             m_cout;
   logic             m_ovf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase    <= 0;
         m_left     <= 0;
         m_res      <= '0;
         m_ovf_pend <= 1'b0;
         m_sum      <= '0;
         m_cout     <= 1'b0;
         m_ovf      <= 1'b0;
      end else begin
         case (m_phase)
            0: if (bus.in_valid) begin
               m_phase    <= 1;
               m_left     <= WIDTH;
               m_res      <= ref_add(bus.a, bus.b, bus.cin);
               m_ovf_pend <= ref_ovf(bus.a, bus.b, bus.cin);
               m_sum      <= '0;
               m_cout     <= 1'b0;
               m_ovf      <= 1'b0;
            end
            1: if (m_left == 1) begin
               m_phase <= 2;
               m_sum   <= m_res[WIDTH-1:0];
               m_cout  <= m_res[WIDTH];
               m_ovf   <= m_ovf_pend;
            end else begin
               m_left <= m_left - 1;
            end
            default: if (bus.out_ready) m_phase <= 0;
         endcase
      end
   end

   logic chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", bus.in_ready, m_phase == 0);
         check("busy", bus.busy, m_phase == 1);
         check("out_valid", bus.out_valid, m_phase == 2);
         // Partial sums during ADD are not a visible result.
         if (m_phase != 1) begin
            check("sum", bus.sum, m_sum);
            check("cout", bus.cout, m_cout);
`ifdef SERIAL_ADDER_OVF_EN
            check("ovf", bus.ovf, m_ovf);
`endif
         end
      end
   end

   // ---------------------------------------------------------------------------
   // One transaction with literal expectations; stall > 0 holds out_ready low
   // for that many cycles in DONE while offering ignored operands.
   // ---------------------------------------------------------------------------
   task automatic run_add(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_b,
                          input logic tcin, input logic [WIDTH-1:0] es, input logic ec,
                          input logic eo, input int stall);
      int n;
      n = 0;
      while (bus.in_ready !== 1'b1 && n < MAX_WAIT) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= MAX_WAIT) check("in_ready_timeout", bus.in_ready, 1);
      bus.a         = ta;
      bus.b         = tb_b;
      bus.cin       = tcin;
      bus.in_valid  = 1'b1;
      bus.out_ready = (stall == 0);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.out_valid !== 1'b1 && n < MAX_WAIT) begin
         @(posedge clk); #1;
         n++;
      end
      check("latency", n, WIDTH);
      check("res_sum", bus.sum, es);
      check("res_cout", bus.cout, ec);
`ifdef SERIAL_ADDER_OVF_EN
      check("res_ovf", bus.ovf, eo);
`else
      if (eo !== ref_ovf(ta, tb_b, tcin)) check("vector_ovf", eo, ref_ovf(ta, tb_b, tcin));
`endif
      if (stall > 0) begin
         bus.in_valid = 1'b1;
         bus.a        = ~ta;
         bus.b        = ta;
         bus.cin      = ~tcin;
         repeat (stall) begin
            @(posedge clk); #1;
            check("stall_out_valid", bus.out_valid, 1);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_sum", bus.sum, es);
            check("stall_cout", bus.cout, ec);
         end
         bus.in_valid  = 1'b0;
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         check("release_in_ready", bus.in_ready, 1);
         check("release_out_valid", bus.out_valid, 0);
         check("retain_sum", bus.sum, es);
         check("retain_cout", bus.cout, ec);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] ra, rb;
      logic             rc;
      logic [WIDTH:0]   rr;

      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.out_ready = 1'b1;

      #12;
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_sum", bus.sum, 0);
      check("rst_cout", bus.cout, 0);
      @(negedge clk); #1;
      rst_n  = 1'b1;
      chk_en = 1'b1;

      //       a      b      cin   sum    cout  ovf   stall
      run_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0);
      run_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
      run_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
      run_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
      run_add(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
      run_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);
      run_add(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0);
      run_add(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, 0);
      run_add(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 5);

      // Reset in the third ADD cycle aborts the addition.
      while (bus.in_ready !== 1'b1) begin
         @(posedge clk); #1;
      end
      bus.a        = 8'h55;
      bus.b        = 8'h11;
      bus.cin      = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("abort_in_ready", bus.in_ready, 1);
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_sum", bus.sum, 0);
      check("abort_cout", bus.cout, 0);
      @(negedge clk); #2;
      rst_n = 1'b1;
      repeat (WIDTH + 2) begin
         @(posedge clk); #1;
         check("abort_no_result", bus.out_valid, 0);
      end
      run_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);

      // Pseudo-random operands with short output stalls.
      for (int i = 0; i < 40; i++) begin
         ra = WIDTH'($urandom);
         rb = WIDTH'($urandom);
         rc = 1'($urandom);
         rr = ref_add(ra, rb, rc);
         run_add(ra, rb, rc, rr[WIDTH-1:0], rr[WIDTH], ref_ovf(ra, rb, rc),
                 int'($urandom_range(0, 3)));
      end

      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
